// File: rtl/cm0_regbank_pkg.sv
// Shared destination codes and arbiter state encoding for the core register-bank write port.
package cm0_regbank_pkg;

    typedef enum logic [2:0] {
        DST_RD      = 3'd0,
        DST_SP      = 3'd1,
        DST_LR      = 3'd2,
        DST_PC      = 3'd3,
        DST_APSR    = 3'd4,
        DST_IPSR    = 3'd5,
        DST_PRIMASK = 3'd6,
        DST_RSVD    = 3'd7
    } dst_e;

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regbank_dst_decode.sv
// Registered decoder: turns the winning transfer into one bank load strobe plus write data/Rd.
module regbank_dst_decode
    import cm0_regbank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p0,
    input  dst_e              dst_p0,
    input  logic [RD_W-1:0]   rd_p0,
    input  logic [DATA_W-1:0] data_p0,
    output logic              ld_sp,
    output logic              ld_lr,
    output logic              ld_pc,
    output logic              ld_rd,
    output logic              ld_apsr,
    output logic              ld_ipsr,
    output logic              ld_primask,
    output logic [DATA_W-1:0] wr_data,
    output logic [RD_W-1:0]   wr_rd,
    output logic              dst_err
);

    // p0 -> p1: strobes are single-cycle; data and Rd hold between transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_sp      <= 1'b0;
            ld_lr      <= 1'b0;
            ld_pc      <= 1'b0;
            ld_rd      <= 1'b0;
            ld_apsr    <= 1'b0;
            ld_ipsr    <= 1'b0;
            ld_primask <= 1'b0;
            dst_err    <= 1'b0;
            wr_data    <= '0;
            wr_rd      <= '0;
        end else begin
            ld_rd      <= vld_p0 && (dst_p0 == DST_RD);
            ld_sp      <= vld_p0 && (dst_p0 == DST_SP);
            ld_lr      <= vld_p0 && (dst_p0 == DST_LR);
            ld_pc      <= vld_p0 && (dst_p0 == DST_PC);
            ld_apsr    <= vld_p0 && (dst_p0 == DST_APSR);
            ld_ipsr    <= vld_p0 && (dst_p0 == DST_IPSR);
            ld_primask <= vld_p0 && (dst_p0 == DST_PRIMASK);
            dst_err    <= vld_p0 && (dst_p0 == DST_RSVD);
            if (vld_p0) begin
                wr_data <= data_p0;
                wr_rd   <= rd_p0;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the register-bank write port between EXE and EXC; EXC has priority and may
// lock the port for a burst, with a starvation counter letting EXE through between bursts.
module regbank_write_arbiter
    import cm0_regbank_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RD_W       = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_req,
    input  logic [2:0]        exe_dst,
    input  logic [RD_W-1:0]   exe_rd,
    input  logic [DATA_W-1:0] exe_data,
    output logic              exe_gnt,
    input  logic              exc_req,
    input  logic [2:0]        exc_dst,
    input  logic [RD_W-1:0]   exc_rd,
    input  logic [DATA_W-1:0] exc_data,
    input  logic              exc_last,
    output logic              exc_gnt,
    output logic              ld_sp,
    output logic              ld_lr,
    output logic              ld_pc,
    output logic              ld_rd,
    output logic              ld_apsr,
    output logic              ld_ipsr,
    output logic              ld_primask,
    output logic [DATA_W-1:0] wr_data,
    output logic [RD_W-1:0]   wr_rd,
    output logic              locked,
    output logic              dst_err
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

    arb_state_e        state;
    logic [SC_W-1:0]   starve_cnt;
    logic              exe_xfer;
    logic              exc_xfer;
    logic              vld_p0;
    dst_e              dst_p0;
    logic [RD_W-1:0]   rd_p0;
    logic [DATA_W-1:0] data_p0;

    always_comb begin
        exe_gnt = 1'b0;
        exc_gnt = 1'b0;
        if (!rst) begin
            if (state == ST_LOCK) begin
                exc_gnt = 1'b1;
            end else if (exc_req && !(exe_req && (starve_cnt == STARVE_TOP))) begin
                exc_gnt = 1'b1;
            end else if (exe_req) begin
                exe_gnt = 1'b1;
            end
        end
    end

    assign exe_xfer = exe_req & exe_gnt;
    assign exc_xfer = exc_req & exc_gnt;

    // p0: winner's fields selected for the decoder
    assign vld_p0  = exe_xfer | exc_xfer;
    assign dst_p0  = exc_gnt ? dst_e'(exc_dst) : dst_e'(exe_dst);
    assign rd_p0   = exc_gnt ? exc_rd : exe_rd;
    assign data_p0 = exc_gnt ? exc_data : exe_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OPEN;
            starve_cnt <= '0;
        end else begin
            if (exc_xfer) begin
                state <= exc_last ? ST_OPEN : ST_LOCK;
            end
            // Denied cycles in ST_LOCK count too, so EXE wins right after a long burst
            if (exe_xfer) begin
                starve_cnt <= '0;
            end else if (exe_req && !exe_gnt && (starve_cnt != STARVE_TOP)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    assign locked = (state == ST_LOCK);

    regbank_dst_decode #(
        .DATA_W(DATA_W),
        .RD_W  (RD_W)
    ) u_decode (
        .clk       (clk),
        .rst       (rst),
        .vld_p0    (vld_p0),
        .dst_p0    (dst_p0),
        .rd_p0     (rd_p0),
        .data_p0   (data_p0),
        .ld_sp     (ld_sp),
        .ld_lr     (ld_lr),
        .ld_pc     (ld_pc),
        .ld_rd     (ld_rd),
        .ld_apsr   (ld_apsr),
        .ld_ipsr   (ld_ipsr),
        .ld_primask(ld_primask),
        .wr_data   (wr_data),
        .wr_rd     (wr_rd),
        .dst_err   (dst_err)
    );

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: single writes, priority, burst lock,
// starvation, reserved code and reset mid-burst.
module tb_regbank_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_req;
    logic [2:0]  exe_dst;
    logic [3:0]  exe_rd;
    logic [31:0] exe_data;
    logic        exe_gnt;
    logic        exc_req;
    logic [2:0]  exc_dst;
    logic [3:0]  exc_rd;
    logic [31:0] exc_data;
    logic        exc_last;
    logic        exc_gnt;
    logic        ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask;
    logic [31:0] wr_data;
    logic [3:0]  wr_rd;
    logic        locked;
    logic        dst_err;
    logic [6:0]  strb;

    int checks = 0;
    int errors = 0;

    // bit 0 = ld_rd ... bit 6 = ld_primask
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_RD   = 7'b0000001;
    localparam logic [6:0] S_SP   = 7'b0000010;
    localparam logic [6:0] S_LR   = 7'b0000100;
    localparam logic [6:0] S_PC   = 7'b0001000;
    localparam logic [6:0] S_APSR = 7'b0010000;
    localparam logic [6:0] S_IPSR = 7'b0100000;
    localparam logic [6:0] S_PMSK = 7'b1000000;

    assign strb = {ld_primask, ld_ipsr, ld_apsr, ld_pc, ld_lr, ld_sp, ld_rd};

    regbank_write_arbiter #(
        .DATA_W    (32),
        .RD_W      (4),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exe_req   (exe_req),
        .exe_dst   (exe_dst),
        .exe_rd    (exe_rd),
        .exe_data  (exe_data),
        .exe_gnt   (exe_gnt),
        .exc_req   (exc_req),
        .exc_dst   (exc_dst),
        .exc_rd    (exc_rd),
        .exc_data  (exc_data),
        .exc_last  (exc_last),
        .exc_gnt   (exc_gnt),
        .ld_sp     (ld_sp),
        .ld_lr     (ld_lr),
        .ld_pc     (ld_pc),
        .ld_rd     (ld_rd),
        .ld_apsr   (ld_apsr),
        .ld_ipsr   (ld_ipsr),
        .ld_primask(ld_primask),
        .wr_data   (wr_data),
        .wr_rd     (wr_rd),
        .locked    (locked),
        .dst_err   (dst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so registered outputs can be sampled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Single-write table
    logic [2:0]  sw_dst  [7];
    logic [3:0]  sw_rd   [7];
    logic [31:0] sw_data [7];
    logic [6:0]  sw_strb [7];

    initial begin
        sw_dst[0] = 3'd1; sw_rd[0] = 4'd1;  sw_data[0] = 32'h2000_0400; sw_strb[0] = S_SP;
        sw_dst[1] = 3'd2; sw_rd[1] = 4'd2;  sw_data[1] = 32'hFFFF_FFF9; sw_strb[1] = S_LR;
        sw_dst[2] = 3'd3; sw_rd[2] = 4'd3;  sw_data[2] = 32'h0000_0100; sw_strb[2] = S_PC;
        sw_dst[3] = 3'd0; sw_rd[3] = 4'd5;  sw_data[3] = 32'hDEAD_BEEF; sw_strb[3] = S_RD;
        sw_dst[4] = 3'd4; sw_rd[4] = 4'd9;  sw_data[4] = 32'hF000_0000; sw_strb[4] = S_APSR;
        sw_dst[5] = 3'd5; sw_rd[5] = 4'd10; sw_data[5] = 32'h0000_0003; sw_strb[5] = S_IPSR;
        sw_dst[6] = 3'd6; sw_rd[6] = 4'd15; sw_data[6] = 32'h0000_0001; sw_strb[6] = S_PMSK;

        rst = 1'b1;
        exe_req = 1'b1; exe_dst = 3'd0; exe_rd = 4'd0; exe_data = 32'h0;
        exc_req = 1'b1; exc_dst = 3'd0; exc_rd = 4'd0; exc_data = 32'h0; exc_last = 1'b1;
        tick();
        chk("rst_exe_gnt", 64'(exe_gnt), 64'd0);
        chk("rst_exc_gnt", 64'(exc_gnt), 64'd0);
        tick();
        exe_req = 1'b0; exc_req = 1'b0;
        rst = 1'b0;
        tick();
        chk("reset_strb",    64'(strb),           64'(S_NONE));
        chk("reset_wr_data", 64'(wr_data),        64'd0);
        chk("reset_wr_rd",   64'(wr_rd),          64'd0);
        chk("reset_dst_err", 64'(dst_err),        64'd0);
        chk("reset_locked",  64'(locked),         64'd0);
        chk("reset_starve",  64'(dut.starve_cnt), 64'd0);

        // Single EXE writes to every destination, back to back
        for (int i = 0; i < 7; i++) begin
            exe_req = 1'b1; exe_dst = sw_dst[i]; exe_rd = sw_rd[i]; exe_data = sw_data[i];
            settle();
            chk("single_gnt", 64'(exe_gnt), 64'd1);
            tick();
            chk("single_strb",    64'(strb),    64'(sw_strb[i]));
            chk("single_wr_data", 64'(wr_data), 64'(sw_data[i]));
            chk("single_wr_rd",   64'(wr_rd),   64'(sw_rd[i]));
        end
        exe_req = 1'b0;
        tick();
        chk("idle_strb",    64'(strb),    64'(S_NONE));
        chk("idle_wr_data", 64'(wr_data), 64'h0000_0001);
        chk("idle_wr_rd",   64'(wr_rd),   64'd15);

        // Priority: EXC single write beats EXE when not starved
        exe_req = 1'b1; exe_dst = 3'd0; exe_rd = 4'd3; exe_data = 32'hAAAA_0001;
        exc_req = 1'b1; exc_dst = 3'd3; exc_rd = 4'd0; exc_data = 32'hBBBB_0002; exc_last = 1'b1;
        settle();
        chk("prio_exc_gnt", 64'(exc_gnt), 64'd1);
        chk("prio_exe_gnt", 64'(exe_gnt), 64'd0);
        tick();
        chk("prio_strb_pc", 64'(strb),    64'(S_PC));
        chk("prio_data_pc", 64'(wr_data), 64'hBBBB_0002);
        chk("prio_locked",  64'(locked),  64'd0);
        exc_req = 1'b0;
        settle();
        chk("prio_exe_next", 64'(exe_gnt), 64'd1);
        tick();
        chk("prio_strb_rd", 64'(strb),           64'(S_RD));
        chk("prio_data_rd", 64'(wr_data),        64'hAAAA_0001);
        chk("prio_rd_idx",  64'(wr_rd),          64'd3);
        chk("prio_starve0", 64'(dut.starve_cnt), 64'd0);

        // Burst lock: IPSR, PC, LR, SP(last) while EXE waits with APSR write
        exe_req = 1'b1; exe_dst = 3'd4; exe_rd = 4'd0; exe_data = 32'h6000_0000;
        exc_req = 1'b1; exc_dst = 3'd5; exc_data = 32'h0000_000B; exc_last = 1'b0;
        settle();
        chk("burst1_exe_gnt", 64'(exe_gnt), 64'd0);
        chk("burst1_exc_gnt", 64'(exc_gnt), 64'd1);
        chk("burst1_locked",  64'(locked),  64'd0);
        tick();
        chk("burst2_strb",   64'(strb),    64'(S_IPSR));
        chk("burst2_data",   64'(wr_data), 64'h0000_000B);
        chk("burst2_locked", 64'(locked),  64'd1);
        exc_dst = 3'd3; exc_data = 32'h0000_0200;
        settle();
        chk("burst2_exe_gnt", 64'(exe_gnt), 64'd0);
        tick();
        chk("burst3_strb",   64'(strb),    64'(S_PC));
        chk("burst3_data",   64'(wr_data), 64'h0000_0200);
        chk("burst3_locked", 64'(locked),  64'd1);
        exc_dst = 3'd2; exc_data = 32'hFFFF_FFF1;
        settle();
        chk("burst3_exe_gnt", 64'(exe_gnt), 64'd0);
        tick();
        chk("burst4_strb",   64'(strb),   64'(S_LR));
        chk("burst4_locked", 64'(locked), 64'd1);
        exc_dst = 3'd1; exc_data = 32'h2000_0F00; exc_last = 1'b1;
        settle();
        chk("burst4_exe_gnt", 64'(exe_gnt), 64'd0);
        chk("burst4_exc_gnt", 64'(exc_gnt), 64'd1);
        tick();
        chk("burst5_strb",   64'(strb),           64'(S_SP));
        chk("burst5_data",   64'(wr_data),        64'h2000_0F00);
        chk("burst5_locked", 64'(locked),         64'd0);
        chk("burst5_starve", 64'(dut.starve_cnt), 64'd4);
        exc_req = 1'b0;
        settle();
        chk("burst5_exe_gnt", 64'(exe_gnt), 64'd1);
        tick();
        chk("burst6_strb",   64'(strb),           64'(S_APSR));
        chk("burst6_data",   64'(wr_data),        64'h6000_0000);
        chk("burst6_starve", 64'(dut.starve_cnt), 64'd0);

        // Starvation: continuous EXC single writes, EXE wins on the 5th cycle
        exe_req = 1'b1; exe_dst = 3'd2; exe_rd = 4'd0; exe_data = 32'h1234_5678;
        exc_req = 1'b1; exc_dst = 3'd6; exc_data = 32'h0000_0001; exc_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("starve_exe_deny", 64'(exe_gnt), 64'd0);
            chk("starve_exc_gnt",  64'(exc_gnt), 64'd1);
            tick();
            chk("starve_strb", 64'(strb),           64'(S_PMSK));
            chk("starve_cnt",  64'(dut.starve_cnt), 64'(i + 1));
        end
        settle();
        chk("starve_exe_win", 64'(exe_gnt), 64'd1);
        chk("starve_exc_off", 64'(exc_gnt), 64'd0);
        tick();
        chk("starve_strb_lr", 64'(strb),           64'(S_LR));
        chk("starve_data_lr", 64'(wr_data),        64'h1234_5678);
        chk("starve_cnt_clr", 64'(dut.starve_cnt), 64'd0);
        settle();
        chk("starve_exc_back", 64'(exc_gnt), 64'd1);
        exe_req = 1'b0; exc_req = 1'b0;
        tick();

        // Reserved destination code
        exe_req = 1'b1; exe_dst = 3'd7; exe_rd = 4'd6; exe_data = 32'hC0DE_0007;
        settle();
        chk("rsvd_gnt", 64'(exe_gnt), 64'd1);
        tick();
        chk("rsvd_dst_err", 64'(dst_err), 64'd1);
        chk("rsvd_strb",    64'(strb),    64'(S_NONE));
        chk("rsvd_data",    64'(wr_data), 64'hC0DE_0007);
        exe_req = 1'b0;
        tick();
        chk("rsvd_err_pulse", 64'(dst_err), 64'd0);

        // Reset during cycle 2 of an EXC burst
        exc_req = 1'b1; exc_dst = 3'd5; exc_data = 32'h0000_0010; exc_last = 1'b0;
        tick();
        chk("rstb_locked", 64'(locked), 64'd1);
        rst = 1'b1;
        exc_dst = 3'd3; exc_data = 32'h0000_0300;
        settle();
        chk("rstb_exc_gnt", 64'(exc_gnt), 64'd0);
        tick();
        rst = 1'b0;
        exc_req = 1'b0;
        exe_req = 1'b1; exe_dst = 3'd0; exe_rd = 4'd7; exe_data = 32'h7777_0000;
        settle();
        chk("rstb_locked_clr", 64'(locked),  64'd0);
        chk("rstb_strb",       64'(strb),    64'(S_NONE));
        chk("rstb_wr_data",    64'(wr_data), 64'd0);
        chk("rstb_exe_gnt",    64'(exe_gnt), 64'd1);
        tick();
        chk("rstb_strb_rd", 64'(strb),  64'(S_RD));
        chk("rstb_rd_idx",  64'(wr_rd), 64'd7);
        exe_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
